// File: rtl/hpdcache_sram_1rw_arb.sv
// hpdcache_sram_1rw_arb
// Shares one single-port 1RW SRAM between a write requester and a read
// requester. Round-robin arbitration gives one access per cycle. Read
// responses have a one-entry holding buffer, so backpressure cannot drop data.
// Optional feature macro: HPDCACHE_SRAM_ARB_INIT_EN. When it is defined, a
// post-reset sequencer writes INIT_VALUE to every word before the ports open.
`timescale 1ns/1ps
module hpdcache_sram_1rw_arb #(
  parameter int unsigned          ADDR_SIZE  = 6,
  parameter int unsigned          DATA_SIZE  = 64,
  parameter int unsigned          DEPTH      = 2**ADDR_SIZE,
  parameter logic [DATA_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wreq_valid,
  output logic                 wreq_ready,
  input  logic [ADDR_SIZE-1:0] wreq_addr,
  input  logic [DATA_SIZE-1:0] wreq_wdata,
  input  logic                 rreq_valid,
  output logic                 rreq_ready,
  input  logic [ADDR_SIZE-1:0] rreq_addr,
  output logic                 rrsp_valid,
  input  logic                 rrsp_ready,
  output logic [DATA_SIZE-1:0] rrsp_rdata,
  output logic                 init_done,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0] sram_wdata,
  input  logic [DATA_SIZE-1:0] sram_rdata
);

  // An illegal depth or a mis-sized fill pattern is rejected at elaboration
  if (DEPTH < 1 || DEPTH > (1 << ADDR_SIZE) || $bits(INIT_VALUE) != DATA_SIZE) begin : g_bad_cfg
    $error("hpdcache_sram_1rw_arb: DEPTH out of range 1..2**ADDR_SIZE");
  end

  // rr_last records which requester won the most recent grant
  typedef enum logic {RR_WRITE = 1'b0, RR_READ = 1'b1} rr_e;

  rr_e                  rr_last_q;
  logic                 rd_inflight_q;
  logic                 hold_valid_q;
  logic [DATA_SIZE-1:0] hold_q;

  logic                 init_active;  // sequencer owns the SRAM this cycle
  logic                 port_open;    // requesters may be granted
  logic                 rd_blocked, rd_cand, wr_cand;
  logic                 grant_rd, grant_wr;
  logic [ADDR_SIZE-1:0] init_addr;

`ifdef HPDCACHE_SRAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] init_cnt_q, init_cnt_d;

  // FSM state and fill counter; reset always restarts the fill from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Walk the counter once across the array, then leave INIT after the last word
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == ADDR_SIZE'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  assign init_active = rst_n & (state_q == ST_INIT);
  assign port_open   = rst_n & (state_q == ST_RUN);
  assign init_addr   = init_cnt_q;
`else
  // Without the sequencer the ports open as soon as reset is released
  assign init_active = 1'b0;
  assign port_open   = rst_n;
  assign init_addr   = '0;
`endif

  assign init_done = port_open;

  // A response that cannot leave this cycle blocks new reads, so at most
  // one response is ever outstanding between the SRAM and the hold buffer
  assign rrsp_valid = rd_inflight_q | hold_valid_q;
  assign rrsp_rdata = hold_valid_q ? hold_q : sram_rdata;
  assign rd_blocked = rrsp_valid & ~rrsp_ready;
  assign rd_cand    = port_open & rreq_valid & ~rd_blocked;
  assign wr_cand    = port_open & wreq_valid;

  // On contention, the requester that did not win last time gets the grant
  assign grant_wr = wr_cand & (~rd_cand | (rr_last_q == RR_READ));
  assign grant_rd = rd_cand & (~wr_cand | (rr_last_q == RR_WRITE));

  // SRAM command mux: sequencer, then the granted requester, otherwise idle
  always_comb begin
    wreq_ready = 1'b0;
    rreq_ready = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (init_active) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = init_addr;
      sram_wdata = INIT_VALUE;
    end else if (grant_wr) begin
      wreq_ready = 1'b1;
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = wreq_addr;
      sram_wdata = wreq_wdata;
    end else if (grant_rd) begin
      rreq_ready = 1'b1;
      sram_cs    = 1'b1;
      sram_addr  = rreq_addr;
    end
  end

  // Arbitration history moves only when something is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rr_last_q <= RR_READ;
    else if (grant_wr) rr_last_q <= RR_WRITE;
    else if (grant_rd) rr_last_q <= RR_READ;
  end

  // Response tracking: capture stalled SRAM data before the next access
  // overwrites sram_rdata, and release it once the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight_q <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_q        <= '0;
    end else begin
      rd_inflight_q <= grant_rd;
      if (rd_inflight_q && !rrsp_ready) begin
        hold_q       <= sram_rdata;
        hold_valid_q <= 1'b1;
      end else if (hold_valid_q && rrsp_ready) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_sram_1rw_arb.sv
// Directed testbench for hpdcache_sram_1rw_arb. The SRAM is modelled in the
// bench with a one-cycle read latency; rdata also updates on write cycles,
// returning the written word. Inputs change on the falling edge and outputs
// are checked 1 ns later. The checks follow HPDCACHE_SRAM_ARB_INIT_EN.
`timescale 1ns/1ps
module tb_hpdcache_sram_1rw_arb;
  localparam int AW = 6;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wreq_valid = 1'b0, wreq_ready;
  logic [AW-1:0] wreq_addr = '0;
  logic [DW-1:0] wreq_wdata = '0;
  logic          rreq_valid = 1'b0, rreq_ready;
  logic [AW-1:0] rreq_addr = '0;
  logic          rrsp_valid, rrsp_ready = 1'b1;
  logic [DW-1:0] rrsp_rdata;
  logic          init_done;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  hpdcache_sram_1rw_arb #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr), .wreq_wdata(wreq_wdata),
    .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
    .rrsp_valid(rrsp_valid), .rrsp_ready(rrsp_ready), .rrsp_rdata(rrsp_rdata),
    .init_done(init_done),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro model
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        sram_rdata     <= sram_wdata;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    wreq_valid = 1'b1; rreq_valid = 1'b1; #1;
    checks++; if (wreq_ready !== 1'b0) begin failures++; $display("FAIL reset_wready: got %b want 0", wreq_ready); end
    checks++; if (rreq_ready !== 1'b0) begin failures++; $display("FAIL reset_rready: got %b want 0", rreq_ready); end
    checks++; if (rrsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rrsp_valid: got %b want 0", rrsp_valid); end
    checks++; if (sram_cs !== 1'b0) begin failures++; $display("FAIL reset_cs: got %b want 0", sram_cs); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b want 0", init_done); end
  endtask

`ifdef HPDCACHE_SRAM_ARB_INIT_EN
  task automatic test_init();
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if ({sram_cs, sram_we} !== 2'b11) begin failures++; $display("FAIL init_cs_we[%0d]: got %b want 11", i, {sram_cs, sram_we}); end
      checks++; if (sram_addr !== AW'(i)) begin failures++; $display("FAIL init_addr[%0d]: got %0d want %0d", i, sram_addr, i); end
      checks++; if (sram_wdata !== '0) begin failures++; $display("FAIL init_wdata[%0d]: got %h want 0", i, sram_wdata); end
      checks++; if ({init_done, wreq_ready, rreq_ready} !== 3'b000) begin failures++; $display("FAIL init_closed[%0d]: got %b want 000", i, {init_done, wreq_ready, rreq_ready}); end
    end
    @(negedge clk); wreq_valid = 1'b0; rreq_valid = 1'b0; #1;
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done_rise: got %b want 1", init_done); end
    checks++; if (sram_cs !== 1'b0) begin failures++; $display("FAIL init_idle_cs: got %b want 0", sram_cs); end
  endtask
`else
  task automatic test_init();
    @(negedge clk); rst_n = 1'b1; rreq_valid = 1'b0;
    wreq_valid = 1'b1; wreq_addr = 6'd3; wreq_wdata = 64'hA5; #1;
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL noinit_done: got %b want 1", init_done); end
    checks++; if (wreq_ready !== 1'b1) begin failures++; $display("FAIL noinit_wready: got %b want 1", wreq_ready); end
    checks++; if ({sram_cs, sram_we, sram_addr, sram_wdata} !== {2'b11, 6'd3, 64'hA5}) begin
      failures++; $display("FAIL noinit_cmd: got cs=%b we=%b a=%0d d=%h want 1 1 3 a5", sram_cs, sram_we, sram_addr, sram_wdata); end
  endtask
`endif

  // Write then read of the same address in consecutive cycles
  task automatic test_basic_rw();
    @(negedge clk); rrsp_ready = 1'b1;
    wreq_valid = 1'b1; wreq_addr = 6'd3; wreq_wdata = 64'hA5; #1;
    checks++; if (wreq_ready !== 1'b1) begin failures++; $display("FAIL rw_wready: got %b want 1", wreq_ready); end
    @(negedge clk); wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 6'd3; #1;
    checks++; if ({rreq_ready, sram_cs, sram_we, sram_addr} !== {3'b110, 6'd3}) begin
      failures++; $display("FAIL rw_rgrant: got rdy=%b cs=%b we=%b a=%0d want 1 1 0 3", rreq_ready, sram_cs, sram_we, sram_addr); end
    @(negedge clk); rreq_valid = 1'b0; #1;
    checks++; if ({rrsp_valid, rrsp_rdata} !== {1'b1, 64'hA5}) begin
      failures++; $display("FAIL rw_raw_data: got v=%b d=%h want 1 a5", rrsp_valid, rrsp_rdata); end
`ifdef HPDCACHE_SRAM_ARB_INIT_EN
    @(negedge clk); rreq_valid = 1'b1; rreq_addr = 6'd37; #1;
    checks++; if (rreq_ready !== 1'b1) begin failures++; $display("FAIL rw_r37_ready: got %b want 1", rreq_ready); end
    @(negedge clk); rreq_valid = 1'b0; #1;
    checks++; if ({rrsp_valid, rrsp_rdata} !== {1'b1, 64'h0}) begin
      failures++; $display("FAIL rw_init37: got v=%b d=%h want 1 0", rrsp_valid, rrsp_rdata); end
`endif
  endtask

  // Both requesters hold valid; the last grant before this was a read
  task automatic test_contention();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      wreq_valid = (k < 8); wreq_addr = 6'd5; wreq_wdata = 64'h11;
      rreq_valid = (k < 8); rreq_addr = 6'd5; #1;
      if (k < 8) begin
        checks++; if ({wreq_ready, rreq_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          failures++; $display("FAIL cont_grant[%0d]: got w=%b r=%b want %s", k, wreq_ready, rreq_ready, (k % 2 == 0) ? "W" : "R"); end
      end
      if (k >= 2 && k % 2 == 0) begin
        checks++; if ({rrsp_valid, rrsp_rdata} !== {1'b1, 64'h11}) begin
          failures++; $display("FAIL cont_rsp[%0d]: got v=%b d=%h want 1 11", k, rrsp_valid, rrsp_rdata); end
      end
      if (k % 2 == 1) begin
        checks++; if (rrsp_valid !== 1'b0) begin failures++; $display("FAIL cont_norsp[%0d]: got %b want 0", k, rrsp_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk); wreq_valid = 1'b1; wreq_addr = 6'd9; wreq_wdata = 64'hBEEF; rreq_valid = 1'b0; #1;
    checks++; if (wreq_ready !== 1'b1) begin failures++; $display("FAIL bp_prewrite: got %b want 1", wreq_ready); end
    @(negedge clk); wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 6'd9; rrsp_ready = 1'b0; #1;
    checks++; if (rreq_ready !== 1'b1) begin failures++; $display("FAIL bp_rgrant: got %b want 1", rreq_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      wreq_valid = (c == 0); wreq_wdata = 64'h1234; #1;
      if (c == 0) begin
        checks++; if (wreq_ready !== 1'b1) begin failures++; $display("FAIL bp_wgrant: got %b want 1", wreq_ready); end
      end
      checks++; if (rreq_ready !== 1'b0) begin failures++; $display("FAIL bp_rblocked[%0d]: got %b want 0", c, rreq_ready); end
      checks++; if ({rrsp_valid, rrsp_rdata} !== {1'b1, 64'hBEEF}) begin
        failures++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want 1 beef", c, rrsp_valid, rrsp_rdata); end
    end
    @(negedge clk); rreq_valid = 1'b0; rrsp_ready = 1'b1; #1;
    checks++; if ({rrsp_valid, rrsp_rdata} !== {1'b1, 64'hBEEF}) begin
      failures++; $display("FAIL bp_pop: got v=%b d=%h want 1 beef", rrsp_valid, rrsp_rdata); end
    @(negedge clk); rreq_valid = 1'b1; #1;
    checks++; if ({rrsp_valid, rreq_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_drained: got v=%b rdy=%b want 0 1", rrsp_valid, rreq_ready); end
    @(negedge clk); rreq_valid = 1'b0; #1;
    checks++; if ({rrsp_valid, rrsp_rdata} !== {1'b1, 64'h1234}) begin
      failures++; $display("FAIL bp_newdata: got v=%b d=%h want 1 1234", rrsp_valid, rrsp_rdata); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); wreq_valid = 1'b1; wreq_addr = AW'(16 + i); wreq_wdata = DW'(256 + i); #1;
      checks++; if (wreq_ready !== 1'b1) begin failures++; $display("FAIL b2b_wr[%0d]: got %b want 1", i, wreq_ready); end
    end
    for (int k = 0; k < 18; k++) begin
      @(negedge clk); wreq_valid = 1'b0; rreq_valid = (k < 16); rreq_addr = AW'(16 + k); #1;
      if (k < 16) begin
        checks++; if (rreq_ready !== 1'b1) begin failures++; $display("FAIL b2b_rready[%0d]: got %b want 1", k, rreq_ready); end
      end
      if (k >= 1 && k <= 16) begin
        checks++; if ({rrsp_valid, rrsp_rdata} !== {1'b1, DW'(256 + k - 1)}) begin
          failures++; $display("FAIL b2b_rsp[%0d]: got v=%b d=%h want 1 %h", k - 1, rrsp_valid, rrsp_rdata, 256 + k - 1); end
      end
      if (k == 17) begin
        checks++; if (rrsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: got %b want 0", rrsp_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); rreq_valid = 1'b1; rreq_addr = 6'd9; rrsp_ready = 1'b0; #1;
    checks++; if (rreq_ready !== 1'b1) begin failures++; $display("FAIL rmid_rgrant: got %b want 1", rreq_ready); end
    @(negedge clk); rreq_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if ({rrsp_valid, rrsp_rdata} !== {1'b1, 64'h1234}) begin
      failures++; $display("FAIL rmid_held: got v=%b d=%h want 1 1234", rrsp_valid, rrsp_rdata); end
    wreq_valid = 1'b1; rreq_valid = 1'b1; rst_n = 1'b0; #1;
    checks++; if (rrsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_drop: got %b want 0", rrsp_valid); end
    checks++; if ({sram_cs, wreq_ready, rreq_ready, init_done} !== 4'b0000) begin
      failures++; $display("FAIL rmid_quiet: got %b want 0000", {sram_cs, wreq_ready, rreq_ready, init_done}); end
    @(negedge clk); rst_n = 1'b1; wreq_valid = 1'b0; rreq_valid = 1'b0; rrsp_ready = 1'b1; #1;
`ifdef HPDCACHE_SRAM_ARB_INIT_EN
    checks++; if ({sram_cs, sram_we, sram_addr, init_done} !== {2'b11, 6'd0, 1'b0}) begin
      failures++; $display("FAIL rmid_init0: got cs=%b we=%b a=%0d done=%b want 1 1 0 0", sram_cs, sram_we, sram_addr, init_done); end
    @(negedge clk); #1;
    checks++; if (sram_addr !== 6'd1) begin failures++; $display("FAIL rmid_init1: got %0d want 1", sram_addr); end
`else
    checks++; if ({init_done, sram_cs, rrsp_valid} !== 3'b100) begin
      failures++; $display("FAIL rmid_run: got %b want 100", {init_done, sram_cs, rrsp_valid}); end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic_rw();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
